// File: rtl/sad_pkg.sv
// Shared constants, FSM encoding and helpers for the SAD FIFO pixel reader.
package sad_pkg;

    localparam int unsigned PIX_W            = 8;
    localparam int unsigned PIX_PER_WORD_DEF = 4;
    localparam int unsigned BLOCK_PIX_DEF    = 256;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    function automatic int unsigned word_count(input int unsigned block_pix,
                                               input int unsigned ppw);
        return block_pix / ppw;
    endfunction

endpackage

// File: rtl/sad_fifo_pixel_reader_if.sv
// FIFO read port and packed-word stream between the pixel reader and its neighbours.
interface sad_fifo_pixel_reader_if #(
    parameter int unsigned PIX_W        = 8,
    parameter int unsigned PIX_PER_WORD = 4
);

    logic                          fifo_rd;
    logic                          fifo_empty;
    logic [PIX_W-1:0]              fifo_data;
    logic [PIX_W*PIX_PER_WORD-1:0] word_data;
    logic                          word_valid;
    logic                          word_ready;
    logic                          word_last;

    modport master (
        output fifo_rd,
        input  fifo_empty,
        input  fifo_data,
        output word_data,
        output word_valid,
        output word_last,
        input  word_ready
    );

    modport slave (
        input  fifo_rd,
        output fifo_empty,
        output fifo_data,
        input  word_data,
        input  word_valid,
        input  word_last,
        output word_ready
    );

endinterface

// File: rtl/sad_pixel_packer.sv
// Little-endian byte packer with a one-entry skid and a registered valid/ready output.
module sad_pixel_packer
    import sad_pkg::*;
#(
    parameter int unsigned PIX_PER_WORD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [PIX_W-1:0]              in_data,
    input  logic                          in_last,
    output logic                          byte_accept,
    output logic                          stall,
    output logic                          skid_full,
    output logic [PIX_W*PIX_PER_WORD-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last
);

    localparam int unsigned LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    logic [LANE_W-1:0]                   lane_q, lane_d;
    logic [PIX_PER_WORD-1:0][PIX_W-1:0]  pack_q, pack_d;
    logic                                pack_full_q, pack_full_d;
    logic                                pack_last_q, pack_last_d;
    logic                                skid_valid_q, skid_valid_d;
    logic [PIX_W-1:0]                    skid_q, skid_d;
    logic [PIX_PER_WORD-1:0][PIX_W-1:0]  out_q, out_d;
    logic                                out_valid_q, out_valid_d;
    logic                                out_last_q, out_last_d;

    logic             out_free;
    logic             src_valid;
    logic [PIX_W-1:0] src_data;
    logic             lane_end;

    assign out_free  = !out_valid_q || out_ready;
    assign src_valid = skid_valid_q || in_valid;
    // A parked skid byte is always older than anything arriving from the FIFO.
    assign src_data  = skid_valid_q ? skid_q : in_data;
    assign lane_end  = (lane_q == LANE_W'(PIX_PER_WORD - 1));

    assign stall     = pack_full_q && !out_free;
    assign skid_full = skid_valid_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    always_comb begin
        lane_d       = lane_q;
        pack_d       = pack_q;
        pack_full_d  = pack_full_q;
        pack_last_d  = pack_last_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        byte_accept  = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (pack_full_q) begin
            if (out_free) begin
                out_d        = pack_q;
                out_valid_d  = 1'b1;
                out_last_d   = pack_last_q;
                pack_full_d  = 1'b0;
                if (src_valid) begin
                    pack_d[lane_q] = src_data;
                    lane_d         = lane_q + LANE_W'(1);
                    byte_accept    = 1'b1;
                    skid_valid_d   = 1'b0;
                end
            end else if (in_valid) begin
                skid_valid_d = 1'b1;
                skid_d       = in_data;
            end
        end else if (src_valid) begin
            byte_accept    = 1'b1;
            skid_valid_d   = 1'b0;
            pack_d[lane_q] = src_data;
            if (lane_end) begin
                lane_d = '0;
                // Bypass straight into the output register so a word appears one cycle
                // after its final byte when the output is free.
                if (out_free) begin
                    out_d       = pack_d;
                    out_valid_d = 1'b1;
                    out_last_d  = in_last;
                end else begin
                    pack_full_d = 1'b1;
                    pack_last_d = in_last;
                end
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q       <= '0;
            pack_q       <= '0;
            pack_full_q  <= 1'b0;
            pack_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else if (clear) begin
            lane_q       <= '0;
            pack_full_q  <= 1'b0;
            pack_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            pack_full_q  <= pack_full_d;
            pack_last_q  <= pack_last_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

endmodule

// File: rtl/sad_fifo_pixel_reader.sv
// Drains one block of pixels from the synchronous FIFO and streams packed words to the SAD engine.
module sad_fifo_pixel_reader
    import sad_pkg::*;
#(
    parameter int unsigned PIX_PER_WORD = PIX_PER_WORD_DEF,
    parameter int unsigned BLOCK_PIX    = BLOCK_PIX_DEF,
    parameter int unsigned CNT_W        = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    sad_fifo_pixel_reader_if.master  bus,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         pix_count
);

    localparam int unsigned NUM_WORDS = word_count(BLOCK_PIX, PIX_PER_WORD);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] pix_q;
    logic [CNT_W-1:0] words_q;
    logic             inflight_q;
    logic             done_q;

    logic clear;
    logic stall;
    logic skid_full;
    logic byte_accept;
    logic word_hs;
    logic in_last;

    assign clear   = (state_q == ST_IDLE) && start;
    assign word_hs = bus.word_valid && bus.word_ready;
    assign in_last = (pix_q == CNT_W'(BLOCK_PIX - 1));

    // Only one byte may ever be in flight beyond what the packer and skid can absorb.
    assign bus.fifo_rd = (state_q == ST_FETCH) && !bus.fifo_empty &&
                         (issued_q < CNT_W'(BLOCK_PIX)) && !skid_full && !stall;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: if (issued_q == CNT_W'(BLOCK_PIX)) state_d = ST_DRAIN;
            ST_DRAIN: if (word_hs && (words_q == CNT_W'(NUM_WORDS - 1))) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            issued_q   <= '0;
            pix_q      <= '0;
            words_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= bus.fifo_rd;
            done_q     <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
            if (clear) begin
                issued_q <= '0;
                pix_q    <= '0;
                words_q  <= '0;
            end else begin
                if (bus.fifo_rd) issued_q <= issued_q + CNT_W'(1);
                if (byte_accept) pix_q    <= pix_q + CNT_W'(1);
                if (word_hs)     words_q  <= words_q + CNT_W'(1);
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign pix_count = pix_q;

    sad_pixel_packer #(
        .PIX_PER_WORD (PIX_PER_WORD)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (inflight_q),
        .in_data     (bus.fifo_data),
        .in_last     (in_last),
        .byte_accept (byte_accept),
        .stall       (stall),
        .skid_full   (skid_full),
        .out_data    (bus.word_data),
        .out_valid   (bus.word_valid),
        .out_ready   (bus.word_ready),
        .out_last    (bus.word_last)
    );

endmodule

// File: tb/tb_sad_fifo_pixel_reader.sv
// Scoreboard bench: FIFO model feeds the reader, expected words come from plain byte arithmetic.
module tb_sad_fifo_pixel_reader;
    import sad_pkg::*;

    localparam int unsigned PPW  = 4;
    localparam int unsigned BP   = 256;
    localparam int unsigned NW   = BP / PPW;
    localparam int unsigned BP16 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start16;
    logic       busy, done, busy16, done16;
    logic [8:0] pix_count;
    logic [4:0] pix_count16;

    sad_fifo_pixel_reader_if #(.PIX_W(PIX_W), .PIX_PER_WORD(PPW)) bus ();
    sad_fifo_pixel_reader_if #(.PIX_W(PIX_W), .PIX_PER_WORD(PPW)) bus16 ();

    sad_fifo_pixel_reader #(.PIX_PER_WORD(PPW), .BLOCK_PIX(BP), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .pix_count(pix_count)
    );

    sad_fifo_pixel_reader #(.PIX_PER_WORD(PPW), .BLOCK_PIX(BP16), .CNT_W(5)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .bus(bus16),
        .busy(busy16), .done(done16), .pix_count(pix_count16)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 256-deep synchronous FIFO model with a one-cycle registered read.
    logic [7:0] mem [256];
    logic [7:0] wptr, rptr;
    int         fcount;
    logic       push;
    logic [7:0] push_data;

    always @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            fcount        <= 0;
            bus.fifo_data <= '0;
        end else begin
            if (bus.fifo_rd) begin
                bus.fifo_data <= mem[rptr];
                rptr          <= rptr + 8'd1;
            end
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 8'd1;
            end
            fcount <= fcount + (push ? 1 : 0) - (bus.fifo_rd ? 1 : 0);
        end
    end
    assign bus.fifo_empty = (fcount == 0);

    // Always-full source for the small-block instance.
    int cnt16;
    always @(posedge clk) begin
        if (rst) begin
            cnt16           <= 0;
            bus16.fifo_data <= '0;
        end else if (bus16.fifo_rd) begin
            bus16.fifo_data <= 8'hA0 + 8'(cnt16);
            cnt16           <= cnt16 + 1;
        end
    end
    assign bus16.fifo_empty = 1'b0;

    logic [7:0]  feed_q[$];
    int          feed_gap = 1;
    int          ready_mode = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp16_q[$];

    initial begin
        int cyc;
        cyc = 0;
        push = 1'b0;
        push_data = '0;
        bus.word_ready = 1'b1;
        bus16.word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            push = 1'b0;
            if (feed_q.size() > 0 && fcount < 256 && (cyc % feed_gap) == 0) begin
                push = 1'b1;
                push_data = feed_q.pop_front();
            end
            case (ready_mode)
                0:       bus.word_ready = 1'b1;
                1:       bus.word_ready = (cyc % 3) == 0;
                default: bus.word_ready = 1'($urandom_range(0, 1));
            endcase
            bus16.word_ready = 1'($urandom_range(0, 1));
        end
    end

    int mcyc = 0, rd_total = 0, rd_run = 0, rd_run_max = 0, done_cnt = 0;
    int last_hs_cyc = -10, first_rd_cyc = -1, first_valid_cyc = -1;
    int done16_cnt = 0, words16 = 0;

    initial begin
        logic        prev_stalled, prev_busy;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [32:0] e;
        prev_stalled = 1'b0;
        prev_busy = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst) begin
                prev_stalled = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (bus.fifo_empty) check("rd_while_empty", bus.fifo_rd, 0);
                if (prev_stalled) begin
                    check("valid_held", bus.word_valid, 1);
                    check("data_held", bus.word_data, prev_data);
                    check("last_held", bus.word_last, prev_last);
                end
                if (bus.word_valid && first_valid_cyc < 0) first_valid_cyc = mcyc;
                if (bus.fifo_rd && first_rd_cyc < 0) first_rd_cyc = mcyc;
                if (bus.word_valid && bus.word_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", bus.word_data, 'x);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", bus.word_data, e[31:0]);
                        check("word_last", bus.word_last, e[32]);
                    end
                    if (bus.word_last) last_hs_cyc = mcyc;
                end
                if (bus.fifo_rd) begin
                    rd_total++;
                    rd_run++;
                    if (rd_run > rd_run_max) rd_run_max = rd_run;
                end else begin
                    rd_run = 0;
                end
                if (prev_busy && !busy) check("busy_falls_with_done", done, 1);
                if (done) begin
                    done_cnt++;
                    check("done_after_last_hs", mcyc, last_hs_cyc + 1);
                    check("busy_low_at_done", busy, 0);
                    check("pix_count_at_done", pix_count, BP);
                end
                if (bus16.word_valid && bus16.word_ready) begin
                    words16++;
                    if (exp16_q.size() == 0) begin
                        check("unexpected_word16", bus16.word_data, 'x);
                    end else begin
                        e = exp16_q.pop_front();
                        check("word16_data", bus16.word_data, e[31:0]);
                        check("word16_last", bus16.word_last, e[32]);
                    end
                end
                if (done16) begin
                    done16_cnt++;
                    check("pix_count16_at_done", pix_count16, BP16);
                end
                prev_stalled = bus.word_valid && !bus.word_ready;
                prev_data = bus.word_data;
                prev_last = bus.word_last;
                prev_busy = busy;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Builds a block, queues its expected words and hands the bytes to the feeder.
    task automatic load_block(input bit ramp);
        logic [7:0]  b [256];
        logic [31:0] w;
        for (int i = 0; i < int'(BP); i++) b[i] = ramp ? 8'(i) : 8'($urandom);
        for (int k = 0; k < int'(NW); k++) begin
            w = 0;
            for (int j = 0; j < int'(PPW); j++) w = w | (32'(b[k*PPW + j]) << (8 * j));
            exp_q.push_back({(k == int'(NW) - 1), w});
        end
        for (int i = 0; i < int'(BP); i++) feed_q.push_back(b[i]);
    endtask

    task automatic preload();
        int t;
        for (t = 0; t < 600 && feed_q.size() > 0; t++) tick(1);
        check("preload_timeout", feed_q.size(), 0);
        tick(2);
    endtask

    task automatic begin_block();
        rd_total = 0;
        rd_run_max = 0;
        done_cnt = 0;
        first_rd_cyc = -1;
        first_valid_cyc = -1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic finish_block(input string name, input int budget);
        int t;
        for (t = 0; t < budget && done_cnt == 0; t++) tick(1);
        check(name, done_cnt > 0, 1);
        tick(20);
        check("single_done", done_cnt, 1);
        check("read_total", rd_total, BP);
        check("words_left", exp_q.size(), 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_fifo_rd", bus.fifo_rd, 0);
        check("rst_word_valid", bus.word_valid, 0);
        check("rst_word_last", bus.word_last, 0);
        check("rst_word_data", bus.word_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_count", pix_count, 0);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        start = 1'b0;
        start16 = 1'b0;
        tick(3);
        check_reset_outputs();
        rst = 1'b0;
        tick(2);

        // Preloaded ramp at full rate.
        ready_mode = 0;
        feed_gap = 1;
        load_block(1'b1);
        preload();
        begin_block();
        finish_block("t1_done_timeout", 2000);
        check("t1_rd_consecutive", rd_run_max, BP);
        check("t1_first_valid_latency", first_valid_cyc - first_rd_cyc, 5);

        // Same data under 1-of-3 backpressure.
        ready_mode = 1;
        load_block(1'b1);
        preload();
        begin_block();
        finish_block("t2_done_timeout", 4000);

        // Slow feeder with random backpressure.
        ready_mode = 2;
        feed_gap = 4;
        load_block(1'b0);
        begin_block();
        finish_block("t3_done_timeout", 4000);

        // Start again mid-fetch must be ignored.
        ready_mode = 0;
        feed_gap = 1;
        load_block(1'b0);
        preload();
        begin_block();
        for (t = 0; t < 1000 && pix_count < 9'd100; t++) tick(1);
        check("t4_reach_100", pix_count >= 9'd100, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        finish_block("t4_done_timeout", 2000);

        // Reset mid-block, then a fresh block.
        load_block(1'b0);
        preload();
        begin_block();
        for (t = 0; t < 1000 && pix_count < 9'd130; t++) tick(1);
        check("t5_reach_130", pix_count >= 9'd130, 1);
        rst = 1'b1;
        feed_q.delete();
        exp_q.delete();
        tick(1);
        check_reset_outputs();
        rst = 1'b0;
        tick(10);
        check("t5_no_done_after_rst", done_cnt, 0);
        load_block(1'b0);
        preload();
        begin_block();
        finish_block("t5_done_timeout", 2000);

        // Small-block instance.
        for (int k = 0; k < int'(BP16 / PPW); k++)
            exp16_q.push_back({(k == int'(BP16 / PPW) - 1),
                               8'hA3 + 8'(4*k), 8'hA2 + 8'(4*k), 8'hA1 + 8'(4*k), 8'hA0 + 8'(4*k)});
        start16 = 1'b1;
        tick(1);
        start16 = 1'b0;
        for (t = 0; t < 500 && done16_cnt == 0; t++) tick(1);
        check("t6_done_timeout", done16_cnt > 0, 1);
        tick(10);
        check("t6_single_done", done16_cnt, 1);
        check("t6_word_count", words16, BP16 / PPW);
        check("t6_words_left", exp16_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
